// File: rtl/dc_feeder_12.sv
// dc_feeder_12: feeds feature windows into one dot channel over the cs x phase schedule.
// Optional issue timeout enabled by defining DC_FEEDER_TIMEOUT_EN.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

// state | meaning
// IDLE  | waiting for start; outputs hold, pulses low
// FETCH | in_ready high, waiting for an upstream window
// ISSUE | loads high, waiting for dc_valid (or timeout)
// GAP   | loads low one cycle, advance cs/phase
// FIN   | done pulse, back to IDLE
module dc_feeder_12 #(
  parameter int N_CS    = 12,
  parameter int N_PHASE = 8,
  parameter int TMO_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [36*`DATA_LEN-1:0]  in_data,
  output logic                     in_ready,
  output logic                     dc_load,
  output logic                     ws_load,
  output logic [3:0]               cs,
  output logic [2:0]               phase,
  output logic [36*`DATA_LEN-1:0]  d,
  input  logic                     dc_valid,
  input  logic [`DATA_LEN-1:0]     dc_q,
  output logic                     res_valid,
  output logic [`DATA_LEN-1:0]     res_data,
  output logic [3:0]               res_cs,
  output logic [2:0]               res_phase,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP, FIN} state_t;

  localparam logic [3:0] CS_LAST  = 4'(N_CS - 1);
  localparam logic [2:0] PH_LAST  = 3'(N_PHASE - 1);
  localparam logic [3:0] TMO_LOAD = 4'(TMO_MAX - 1);

  state_t state, state_nx;
  logic   last_slot;
  logic   tmo_hit;

  assign last_slot = (cs == CS_LAST) && (phase == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (in_valid) state_nx = ISSUE;
      ISSUE:   if (dc_valid || tmo_hit) state_nx = GAP;
      GAP:     state_nx = last_slot ? FIN : FETCH;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == FETCH);
  assign dc_load  = (state == ISSUE);
  assign ws_load  = (state == ISSUE);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      cs        <= '0;
      phase     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cs    <= '0;
      res_phase <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cs    <= '0;
            phase <= '0;
          end
        end
        FETCH: begin
          if (in_valid) d <= in_data;
        end
        ISSUE: begin
          if (dc_valid || tmo_hit) begin
            // a timed-out slot still reports, with zero data, so the consumer sees every tag
            res_data  <= dc_valid ? dc_q : '0;
            res_cs    <= cs;
            res_phase <= phase;
            res_valid <= 1'b1;
          end
        end
        GAP: begin
          if (!last_slot) begin
            if (phase == PH_LAST) begin
              phase <= '0;
              cs    <= cs + 4'd1;
            end else begin
              phase <= phase + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DC_FEEDER_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  // down-counter armed while fetching, expires on the TMO_MAX-th ISSUE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == FETCH)
        tmo_cnt <= TMO_LOAD;
      else if (state == ISSUE && tmo_cnt != 4'd0)
        tmo_cnt <= tmo_cnt - 4'd1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign tmo_hit = (state == ISSUE) && !dc_valid && (tmo_cnt == 4'd0);
  assign err     = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
